alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the 16-bit ALU adder.
- Captures the adder's sum and flags (zero, sign, overflow, parity, carry) through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Presents them registered to the consumer (register file / status bus).
- Maintains sticky overflow/carry status, an accepted-operation counter and a flag-consistency error bit.

---
 rtl/alu_result_stage.sv | 168 ++++++++++++++++
 tb/tb_alu_result_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Registered result stage behind the 16-bit ALU adder.
// Buffers sum + flags in a 2-entry FIFO with valid/ready on both sides.
// It also keeps sticky overflow/carry status, a saturating count of
// accepted results and a sticky zero/sign consistency error.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_EMPTY | no buffered result; out_valid=0, in_ready=1
// S_ONE   | head entry valid on outputs; in_ready=1
// S_FULL  | head + second entry buffered; in_ready=0
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_zero,
    input  logic             in_sign,
    input  logic             in_overflow,
    input  logic             in_parity,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [4:0]       out_flags,
    input  logic             sticky_clr,
    output logic             sticky_ovf,
    output logic             sticky_carry,
    output logic             flag_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   head_sum_q, head_sum_d;
    logic [4:0]         head_flags_q, head_flags_d;
    logic [WIDTH-1:0]   tail_sum_q, tail_sum_d;
    logic [4:0]         tail_flags_q, tail_flags_d;
    logic               sticky_ovf_q, sticky_ovf_d;
    logic               sticky_carry_q, sticky_carry_d;
    logic               flag_err_q, flag_err_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic               push;
    logic               pop;
    logic [4:0]         in_flags;
    logic               in_inconsistent;

    // Handshake decode: ready/valid come from the state register only,
    // so there is no combinational path from out_ready to in_ready.
    always_comb begin
        in_ready        = (state_q != S_FULL);
        out_valid       = (state_q != S_EMPTY);
        push            = in_valid && in_ready;
        pop             = out_valid && out_ready;
        in_flags        = {in_carry, in_parity, in_overflow, in_sign, in_zero};
        in_inconsistent = (in_zero != (in_sum == '0)) ||
                          (in_sign != in_sum[WIDTH-1]);
    end

    // Occupancy FSM and FIFO data movement.
    always_comb begin
        state_d      = state_q;
        head_sum_d   = head_sum_q;
        head_flags_d = head_flags_q;
        tail_sum_d   = tail_sum_q;
        tail_flags_d = tail_flags_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_sum_d   = in_sum;
                    head_flags_d = in_flags;
                    state_d      = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    // head leaves and the new entry takes its place
                    head_sum_d   = in_sum;
                    head_flags_d = in_flags;
                end else if (push) begin
                    tail_sum_d   = in_sum;
                    tail_flags_d = in_flags;
                    state_d      = S_FULL;
                end else if (pop) begin
                    // head registers keep their last value while empty
                    state_d      = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    head_sum_d   = tail_sum_q;
                    head_flags_d = tail_flags_q;
                    state_d      = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // Sticky status and saturating counter; a push coinciding with a
    // clear still records its own event so nothing is lost.
    always_comb begin
        sticky_ovf_d   = sticky_ovf_q;
        sticky_carry_d = sticky_carry_q;
        flag_err_d     = flag_err_q;
        op_count_d     = op_count_q;
        if (sticky_clr) begin
            sticky_ovf_d   = push && in_overflow;
            sticky_carry_d = push && in_carry;
            flag_err_d     = push && in_inconsistent;
            op_count_d     = push ? CNT_W'(1) : '0;
        end else if (push) begin
            sticky_ovf_d   = sticky_ovf_q   || in_overflow;
            sticky_carry_d = sticky_carry_q || in_carry;
            flag_err_d     = flag_err_q     || in_inconsistent;
            if (op_count_q != {CNT_W{1'b1}}) begin
                op_count_d = op_count_q + CNT_W'(1);
            end
        end
    end

    // State, FIFO and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_EMPTY;
            head_sum_q     <= '0;
            head_flags_q   <= '0;
            tail_sum_q     <= '0;
            tail_flags_q   <= '0;
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
            flag_err_q     <= 1'b0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            head_sum_q     <= head_sum_d;
            head_flags_q   <= head_flags_d;
            tail_sum_q     <= tail_sum_d;
            tail_flags_q   <= tail_flags_d;
            sticky_ovf_q   <= sticky_ovf_d;
            sticky_carry_q <= sticky_carry_d;
            flag_err_q     <= flag_err_d;
            op_count_q     <= op_count_d;
        end
    end

    // Outputs are straight from registers.
    always_comb begin
        out_sum      = head_sum_q;
        out_flags    = head_flags_q;
        sticky_ovf   = sticky_ovf_q;
        sticky_carry = sticky_carry_q;
        flag_err     = flag_err_q;
        op_count     = op_count_q;
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a queue-based reference model
// checked every cycle, plus literal spot checks. A second instance with
// a 2-bit counter shares the stimulus to exercise early saturation.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic        in_zero, in_sign, in_overflow, in_parity, in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [4:0]  out_flags;
    logic        sticky_clr;
    logic        sticky_ovf, sticky_carry, flag_err;
    logic [7:0]  op_count;

    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_sum;
    logic [4:0]  s_out_flags;
    logic        s_ovf, s_carry, s_err;
    logic [1:0]  s_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .in_zero(in_zero), .in_sign(in_sign), .in_overflow(in_overflow),
        .in_parity(in_parity), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_flags(out_flags),
        .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf),
        .sticky_carry(sticky_carry), .flag_err(flag_err), .op_count(op_count)
    );

    alu_result_stage #(.WIDTH(16), .CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_sum(in_sum),
        .in_zero(in_zero), .in_sign(in_sign), .in_overflow(in_overflow),
        .in_parity(in_parity), .in_carry(in_carry),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum(s_out_sum), .out_flags(s_out_flags),
        .sticky_clr(sticky_clr), .sticky_ovf(s_ovf),
        .sticky_carry(s_carry), .flag_err(s_err), .op_count(s_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of at most two results, plus status.
    typedef struct packed {
        logic [15:0] s;
        logic [4:0]  f;
    } ent_t;

    ent_t q[$];
    ent_t shown;
    logic m_ovf, m_carry, m_err;
    int   m_cnt;

    always @(posedge clk or negedge rst_n) begin
        bit push, pop, bad;
        if (!rst_n) begin
            q.delete();
            shown   = '0;
            m_ovf   = 1'b0;
            m_carry = 1'b0;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else begin
            pop  = (q.size() > 0) && out_ready;
            push = in_valid && (q.size() < 2);
            bad  = (in_zero != (in_sum == 16'h0)) || (in_sign != in_sum[15]);
            if (pop) void'(q.pop_front());
            if (push) q.push_back({in_sum, {in_carry, in_parity, in_overflow, in_sign, in_zero}});
            if (q.size() > 0) shown = q[0];
            if (sticky_clr) begin
                m_ovf   = push && in_overflow;
                m_carry = push && in_carry;
                m_err   = push && bad;
                m_cnt   = push ? 1 : 0;
            end else if (push) begin
                m_ovf   = m_ovf || in_overflow;
                m_carry = m_carry || in_carry;
                m_err   = m_err || bad;
                m_cnt   = m_cnt + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check("out_valid",    out_valid,    q.size() > 0);
        check("in_ready",     in_ready,     q.size() < 2);
        check("out_sum",      out_sum,      shown.s);
        check("out_flags",    out_flags,    shown.f);
        check("sticky_ovf",   sticky_ovf,   m_ovf);
        check("sticky_carry", sticky_carry, m_carry);
        check("flag_err",     flag_err,     m_err);
        check("op_count",     op_count,     (m_cnt > 255) ? 255 : m_cnt);
        check("small_ready",  s_in_ready,   q.size() < 2);
        check("small_count",  s_cnt,        (m_cnt > 3) ? 3 : m_cnt);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_in(input logic [15:0] s, input logic z, input logic sg,
                          input logic ov, input logic p, input logic c);
        in_valid    = 1'b1;
        in_sum      = s;
        in_zero     = z;
        in_sign     = sg;
        in_overflow = ov;
        in_parity   = p;
        in_carry    = c;
    endtask

    task automatic wait_accept();
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
        end
        if (!acc) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] s, input logic z, input logic sg,
                        input logic ov, input logic p, input logic c);
        set_in(s, z, sg, ov, p, c);
        wait_accept();
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_sum      = '0;
        in_zero     = 1'b0;
        in_sign     = 1'b0;
        in_overflow = 1'b0;
        in_parity   = 1'b0;
        in_carry    = 1'b0;
        out_ready   = 1'b1;
        sticky_clr  = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_sum",   out_sum,   0);
        check("rst_op_count",  op_count,  0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // single push, visible one edge later
        send(16'haaa9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t1_valid",  out_valid,    1);
        check("t1_sum",    out_sum,      16'haaa9);
        check("t1_flags",  out_flags,    5'b10010);
        check("t1_carry",  sticky_carry, 1);
        check("t1_ovf",    sticky_ovf,   0);
        check("t1_count",  op_count,     1);
        step(1);

        // back-pressure, FULL hold-off, pop-without-push from FULL
        out_ready = 1'b0;
        send(16'h4563, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(16'he601, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(16'h10aa, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check("t2_full_ready", in_ready,  0);
        check("t2_hold_sum",   out_sum,   16'h4563);
        check("t2_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        step(1);
        check("t3_pop_sum",    out_sum,   16'he601);
        check("t3_one_ready",  in_ready,  1);
        step(1);
        in_valid = 1'b0;
        check("t3_push_sum",   out_sum,   16'h10aa);
        check("t3_count",      op_count,  4);
        check("t3_err_clean",  flag_err,  0);
        step(1);
        check("t3_empty",      out_valid, 0);
        check("t3_retain",     out_sum,   16'h10aa);

        // flag consistency error is sticky
        send(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_err_set", flag_err, 1);
        send(16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_err_hold", flag_err, 1);
        step(2);

        // push concurrent with clear, then clear alone
        set_in(16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sticky_clr = 1'b1;
        wait_accept();
        sticky_clr = 1'b0;
        check("t5_ovf",   sticky_ovf,   1);
        check("t5_carry", sticky_carry, 0);
        check("t5_err",   flag_err,     0);
        check("t5_count", op_count,     1);
        sticky_clr = 1'b1;
        step(1);
        sticky_clr = 1'b0;
        check("t5c_ovf",   sticky_ovf, 0);
        check("t5c_count", op_count,   0);
        step(1);

        // counter saturation on both instances
        for (int i = 0; i < 270; i++) begin
            set_in(16'(i), (i == 0), 1'b0, 1'b0, 1'b0, 1'b0);
            step(1);
        end
        in_valid = 1'b0;
        check("t6_sat8", op_count, 255);
        check("t6_sat2", s_cnt,    3);
        step(2);

        // asynchronous reset while FULL
        out_ready = 1'b0;
        send(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t7_full", in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_valid", out_valid,  0);
        check("t7_ready", in_ready,   1);
        check("t7_sum",   out_sum,    0);
        check("t7_flags", out_flags,  0);
        check("t7_ovf",   sticky_ovf, 0);
        check("t7_count", op_count,   0);
        step(1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step(3);
        send(16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t7_after_sum", out_sum, 16'h7777);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
